// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus for the program loader.
// The slave modport is the loader's view; master is the host/memory side.
interface imem_loader_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             imem_we;
  logic [31:0]      imem_waddr;
  logic [31:0]      imem_wdata;
  logic             cpu_stall;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] words_loaded;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, imem_we, imem_waddr, imem_wdata,
    input  cpu_stall, busy, done, error, words_loaded
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, imem_we, imem_waddr, imem_wdata,
    output cpu_stall, busy, done, error, words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a program into instruction memory from a length-prefixed big-endian byte
// stream, one write strobe per assembled word, stalling the CPU while it runs.
module imem_loader #(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

  state_t           r_state;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_len;
  logic [23:0]      r_word;
  logic             r_ready;
  logic             r_we;
  logic [31:0]      r_waddr;
  logic [31:0]      r_wdata;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [CNT_W-1:0] r_words;

  logic             w_fire;
  logic [CNT_W-1:0] w_len_next;
  logic [CNT_W-1:0] w_words_inc;
  logic [31:0]      w_addr;

  assign w_fire      = bus.byte_valid && r_ready;
  assign w_len_next  = {r_len[CNT_W-9:0], bus.byte_in};
  assign w_words_inc = r_words + LP_ONE;
  assign w_addr      = {{(30-CNT_W){1'b0}}, r_words, 2'b00};

  // Every output is a register, so each transition sets the values the next state presents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_word  <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_words <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_words <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_HDR;
          end
        end

        S_HDR: begin
          if (w_fire) begin
            r_len <= w_len_next;
            if (r_idx == 2'd1) begin
              r_idx <= '0;
              if (w_len_next == '0) begin
                r_ready <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else if (w_len_next > LP_DEPTH) begin
                r_ready <= 1'b0;
                r_busy  <= 1'b0;
                r_error <= 1'b1;
                r_state <= S_ERR;
              end else begin
                r_state <= S_DATA;
              end
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end

        S_DATA: begin
          if (w_fire) begin
            r_word <= {r_word[15:0], bus.byte_in};
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_we    <= 1'b1;
              r_waddr <= w_addr;
              r_wdata <= {r_word, bus.byte_in};
              r_ready <= 1'b0;
              r_state <= S_WRITE;
            end
          end
        end

        // Upstream is held off for this cycle so the strobe and counter update stay in step.
        S_WRITE: begin
          r_we    <= 1'b0;
          r_words <= w_words_inc;
          if (w_words_inc == r_len) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_DATA;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_ready   = r_ready;
  assign bus.imem_we      = r_we;
  assign bus.imem_waddr   = r_waddr;
  assign bus.imem_wdata   = r_wdata;
  assign bus.cpu_stall    = r_busy;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.error        = r_error;
  assign bus.words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader; expected writes and status
// are derived from the byte stream by a simple arithmetic model.
module tb_imem_loader;
  localparam int DEPTH = 1024;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.CNT_W(CNT_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          nTotal = 0;
  int          nBad = 0;
  int          stallErr = 0;
  int          weReadyBad = 0;
  logic [63:0] gotQ[$];
  logic [7:0]  streamQ[$];

  // Captures every memory write as {addr, data}; a write with byte_ready high is a protocol error.
  always @(negedge clk) begin
    if (bus.imem_we) begin
      gotQ.push_back({bus.imem_waddr, bus.imem_wdata});
      if (bus.byte_ready) weReadyBad++;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTotal++;
    if (got !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int maxGap);
    int gap;
    int waitCnt;
    gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
    bus.byte_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      if (!bus.cpu_stall) stallErr++;
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    waitCnt = 0;
    while (!bus.byte_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
      if (!bus.cpu_stall) stallErr++;
    end
    if (!bus.byte_ready) begin
      checkOutput("byte_ready_timeout", 64'd0, 64'd1);
    end else begin
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic startPulse();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Runs one load of streamQ; busyStartAt is the byte index before which a stray start is pulsed (-1 none).
  task automatic applyStimulus(input string name, input int maxGap, input int busyStartAt);
    int base;
    int wrb0;
    int len;
    int nWords;
    logic expErr;
    logic [31:0] expWord;
    base = gotQ.size();
    wrb0 = weReadyBad;
    stallErr = 0;
    len = int'(streamQ[0]) * 256 + int'(streamQ[1]);
    expErr = (len > DEPTH);
    nWords = expErr ? 0 : len;

    startPulse();
    checkOutput({name, "_busy_after_start"}, 64'(bus.busy), 64'd1);
    checkOutput({name, "_done_cleared"}, 64'(bus.done), 64'd0);

    for (int k = 0; k < streamQ.size(); k++) begin
      if (k == busyStartAt) begin
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
      sendByte(streamQ[k], maxGap);
      if (k >= 2 && ((k - 2) % 4) == 3)
        checkOutput({name, "_we_timing"}, 64'(bus.imem_we), 64'd1);
    end
    if (!(len == 0 || expErr)) @(negedge clk);

    checkOutput({name, "_done"}, 64'(bus.done), 64'(!expErr));
    checkOutput({name, "_error"}, 64'(bus.error), 64'(expErr));
    checkOutput({name, "_busy_end"}, 64'(bus.busy), 64'd0);
    checkOutput({name, "_stall_end"}, 64'(bus.cpu_stall), 64'd0);
    checkOutput({name, "_words_loaded"}, 64'(bus.words_loaded), 64'(nWords));
    checkOutput({name, "_write_count"}, 64'(gotQ.size() - base), 64'(nWords));
    checkOutput({name, "_stall_during_load"}, 64'(stallErr), 64'd0);
    checkOutput({name, "_ready_in_write"}, 64'(weReadyBad - wrb0), 64'd0);
    for (int i = 0; i < nWords && (base + i) < gotQ.size(); i++) begin
      expWord = {streamQ[2+4*i], streamQ[3+4*i], streamQ[4+4*i], streamQ[5+4*i]};
      checkOutput({name, "_write"}, gotQ[base+i], {32'(i * 4), expWord});
    end
  endtask

  task automatic loadBasic();
    streamQ = '{8'h00, 8'h03, 8'h01, 8'h09, 8'h50, 8'h20, 8'hAC, 8'h0A,
                8'h00, 8'h00, 8'h01, 8'h49, 8'h58, 8'h22};
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_flags"},
                64'({bus.byte_ready, bus.imem_we, bus.cpu_stall, bus.busy, bus.done, bus.error}),
                64'd0);
    checkOutput({tag, "_waddr"}, 64'(bus.imem_waddr), 64'd0);
    checkOutput({tag, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
    checkOutput({tag, "_words"}, 64'(bus.words_loaded), 64'd0);
  endtask

  initial begin
    int base;
    int nw;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk);

    loadBasic();
    applyStimulus("basic", 0, -1);
    checkOutput("basic_word2", gotQ[gotQ.size()-1], 64'h00000008_01495822);

    loadBasic();
    applyStimulus("gaps", 5, -1);

    streamQ = '{8'h00, 8'h00};
    applyStimulus("len0", 2, -1);

    streamQ = '{8'h04, 8'h01};
    applyStimulus("over", 2, -1);

    streamQ = '{8'h04, 8'h00};
    for (int i = 0; i < 4 * DEPTH; i++) streamQ.push_back(8'($urandom_range(255, 0)));
    applyStimulus("full", 0, -1);
    checkOutput("full_last_addr", 64'(gotQ[gotQ.size()-1][63:32]), 64'h0FFC);

    for (int r = 0; r < 6; r++) begin
      nw = int'($urandom_range(6, 1));
      streamQ = '{8'h00, 8'(nw)};
      for (int i = 0; i < 4 * nw; i++) streamQ.push_back(8'($urandom_range(255, 0)));
      applyStimulus("rand", 3, -1);
    end

    loadBasic();
    base = gotQ.size();
    startPulse();
    for (int k = 0; k < 8; k++) sendByte(streamQ[k], 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_write_count", 64'(gotQ.size() - base), 64'd1);
    checkOutput("midrst_first_write", gotQ[gotQ.size()-1], 64'h00000000_01095020);
    checkAllZero("midrst");
    @(negedge clk);
    checkOutput("midrst_idle_writes", 64'(gotQ.size() - base), 64'd1);
    applyStimulus("after_rst", 1, -1);

    loadBasic();
    applyStimulus("busy_start", 0, 8);

    streamQ = '{8'h00, 8'h01, 8'h8C, 8'h6A, 8'h00, 8'h03};
    applyStimulus("reload", 1, -1);
    checkOutput("reload_write", gotQ[gotQ.size()-1], 64'h00000000_8C6A0003);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
